// File: rtl/layer_compositor.sv
// Fixed-priority, colour-keyed sprite/maze/background compositor with 2-cycle pixel latency and per-frame player collision flags.
// Optional feature macro: LAYER_COMPOSITOR_COLLIDE_EN builds the collision accumulator (otherwise collision is tied to 0).
module layer_compositor #(
  parameter int          NUM_LAYERS  = 5,
  parameter logic [11:0] KEY_COLOR   = 12'h000,
  parameter logic [11:0] OPAQUE_MASK = 12'h000,
  parameter logic [11:0] OPAQUE_VAL  = 12'h000,
  parameter int          H_LAST      = 799,
  parameter int          V_LAST      = 524,
  parameter int          FCNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bright,
  input  logic [9:0]                 hCount,
  input  logic [9:0]                 vCount,
  input  logic [NUM_LAYERS-1:0]      layer_fill,
  input  logic [12*NUM_LAYERS-1:0]   layer_color,
  input  logic                       maze_fill,
  input  logic [11:0]                maze_color,
  input  logic [11:0]                background,
  output logic [11:0]                rgb,
  output logic                       frame_done,
  output logic [NUM_LAYERS-1:0]      collision,
  output logic [FCNT_W-1:0]          frame_cnt
);

  function automatic logic is_opaque(input logic fill, input logic [11:0] color);
    return fill && (color != KEY_COLOR) && ((color & OPAQUE_MASK) == OPAQUE_VAL);
  endfunction

  logic [NUM_LAYERS-1:0] opaque;
  logic [11:0]           pix_d;
  logic                  frame_end;

  logic [11:0]           pix_p1_q;
  logic                  vld_p1_q;
  logic [11:0]           rgb_p2_q;
  logic                  frame_done_q;
  logic [FCNT_W-1:0]     fcnt_q;

  assign frame_end = (hCount == 10'(H_LAST)) && (vCount == 10'(V_LAST));

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = is_opaque(layer_fill[i], layer_color[12*i +: 12]);
    end
  end

  // Walk from lowest priority upward so the lowest-index opaque layer is the last write.
  always_comb begin
    pix_d = maze_fill ? maze_color : background;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) pix_d = layer_color[12*i +: 12];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_p1_q     <= 12'h000;
      vld_p1_q     <= 1'b0;
      rgb_p2_q     <= 12'h000;
      frame_done_q <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      // stage 1: selected colour and visible flag
      pix_p1_q     <= pix_d;
      vld_p1_q     <= bright;
      // stage 2: blank outside the visible area
      rgb_p2_q     <= vld_p1_q ? pix_p1_q : 12'h000;
      frame_done_q <= frame_end;
      if (frame_end) fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  assign rgb        = rgb_p2_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = fcnt_q;

`ifdef LAYER_COMPOSITOR_COLLIDE_EN
  logic [NUM_LAYERS-1:0] hits;
  logic [NUM_LAYERS-1:0] acc_q, acc_d;
  logic [NUM_LAYERS-1:0] coll_q, coll_d;

  // The frame-end pixel's own hits are folded into the report, not carried into the next frame.
  always_comb begin
    hits = '0;
    for (int i = 1; i < NUM_LAYERS; i++) begin
      hits[i] = bright && opaque[0] && opaque[i];
    end
    acc_d  = acc_q | hits;
    coll_d = coll_q;
    if (frame_end) begin
      coll_d = acc_q | hits;
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= '0;
      coll_q <= '0;
    end else begin
      acc_q  <= acc_d;
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;
`else
  assign collision = '0;
`endif

endmodule
